sha256_msg_feeder: RTL and testbench

//  Initiator side of the SHA-256 block-compression interface. Accepts a byte-aligned

---
 rtl/sha256_msg_feeder.sv | 183 ++++++++++++++++++
 tb/tb_sha256_msg_feeder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_feeder.sv
// rtl/sha256_msg_feeder.sv - SHA-256 message padder and block sequencer for an external compression core
//
// Takes a big-endian 32-bit word stream (first byte in [31:24]), appends the 0x80
// marker, zero fill and 64-bit bit-length, and hands 512-bit blocks to the compression
// core one at a time. The digest of each block is chained into the next; the digest of
// the length-carrying block is published on hash_out.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   msg_*               word stream in (valid/ready handshake, last word + byte count)
//   core_start_out      one-cycle start to the compression core
//   core_message_out    current padded block, W0 in [511:480]
//   core_digest_out     chaining value for the current block
//   core_digest_in/core_valid_in  digest returned by the core
//   hash_out/hash_valid_out       final hash and its one-cycle update strobe
//   busy_out            high whenever a message is in flight
module sha256_msg_feeder #(
  parameter int LEN_W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         msg_valid_in,
  output logic         msg_ready_out,
  input  logic [31:0]  msg_data_in,
  input  logic         msg_last_in,
  input  logic [2:0]   msg_bytes_in,
  output logic         core_start_out,
  output logic [511:0] core_message_out,
  output logic [255:0] core_digest_out,
  input  logic [255:0] core_digest_in,
  input  logic         core_valid_in,
  output logic [255:0] hash_out,
  output logic         hash_valid_out,
  output logic         busy_out
);

  localparam logic [255:0] H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PAD, S_START, S_WAIT, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      blk [16];
  logic [3:0]       word_idx;
  logic [LEN_W-1:0] byte_cnt;
  logic [255:0]     chain;
  logic             msg_done;     // last message word has been accepted
  logic             pad_pending;  // 0x80 marker still owed (message ended on a word boundary)
  logic             len_hi_done;  // word 14 of this block carries the length high half
  logic             final_blk;    // this block carries the full length field

  logic             xfer;
  logic [2:0]       tail_b;
  logic [31:0]      in_word;
  logic [31:0]      pad_word;
  logic [LEN_W-1:0] byte_inc;
  logic [63:0]      len_bits;

  assign len_bits        = 64'(byte_cnt) << 3;
  assign core_digest_out = chain;

  always_comb begin
    core_message_out = '0;
    for (int i = 0; i < 16; i++) core_message_out[511 - 32*i -: 32] = blk[i];
  end

  // Incoming word after tail masking and marker insertion.
  always_comb begin
    tail_b   = (msg_bytes_in > 3'd4) ? 3'd4 : msg_bytes_in;
    in_word  = msg_data_in;
    byte_inc = LEN_W'(4);
    if (msg_last_in) begin
      byte_inc = LEN_W'(tail_b);
      case (tail_b)
        3'd0:    in_word = 32'h8000_0000;
        3'd1:    in_word = {msg_data_in[31:24], 24'h80_0000};
        3'd2:    in_word = {msg_data_in[31:16], 16'h8000};
        3'd3:    in_word = {msg_data_in[31:8], 8'h80};
        default: in_word = msg_data_in;
      endcase
    end
  end

  // Padding word. Once the marker is placed, word 14 starts the length; word 15
  // completes it only if word 14 of this same block took the high half.
  always_comb begin
    if (pad_pending)                       pad_word = 32'h8000_0000;
    else if (word_idx == 4'd14)            pad_word = len_bits[63:32];
    else if (word_idx == 4'd15 && len_hi_done) pad_word = len_bits[31:0];
    else                                   pad_word = '0;
  end

  always_comb begin
    state_nxt      = state;
    msg_ready_out  = 1'b0;
    core_start_out = 1'b0;
    busy_out       = (state != S_IDLE);
    xfer           = 1'b0;
    case (state)
      S_IDLE, S_LOAD: begin
        msg_ready_out = 1'b1;
        xfer          = msg_valid_in;
        if (msg_valid_in) begin
          if (word_idx == 4'd15)  state_nxt = S_START;
          else if (msg_last_in)   state_nxt = S_PAD;
          else                    state_nxt = S_LOAD;
        end
      end
      S_PAD:   if (word_idx == 4'd15) state_nxt = S_START;
      S_START: begin
        core_start_out = 1'b1;
        state_nxt      = S_WAIT;
      end
      S_WAIT: begin
        if (core_valid_in) begin
          if (final_blk)     state_nxt = S_DONE;
          else if (msg_done) state_nxt = S_PAD;
          else               state_nxt = S_LOAD;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= S_IDLE;
      word_idx       <= '0;
      byte_cnt       <= '0;
      chain          <= '0;
      msg_done       <= 1'b0;
      pad_pending    <= 1'b0;
      len_hi_done    <= 1'b0;
      final_blk      <= 1'b0;
      hash_out       <= '0;
      hash_valid_out <= 1'b0;
      for (int i = 0; i < 16; i++) blk[i] <= '0;
    end else begin
      state          <= state_nxt;
      hash_valid_out <= 1'b0;
      case (state)
        S_IDLE, S_LOAD: begin
          if (xfer) begin
            if (state == S_IDLE) chain <= H0;
            blk[word_idx] <= in_word;
            word_idx      <= word_idx + 4'd1;
            byte_cnt      <= byte_cnt + byte_inc;
            if (msg_last_in) begin
              msg_done    <= 1'b1;
              pad_pending <= (tail_b == 3'd4);
            end
          end
        end
        S_PAD: begin
          blk[word_idx] <= pad_word;
          word_idx      <= word_idx + 4'd1;
          if (pad_pending)                         pad_pending <= 1'b0;
          else if (word_idx == 4'd14)              len_hi_done <= 1'b1;
          else if (word_idx == 4'd15 && len_hi_done) final_blk <= 1'b1;
        end
        S_WAIT: begin
          if (core_valid_in) begin
            chain       <= core_digest_in;
            word_idx    <= '0;
            len_hi_done <= 1'b0;
          end
        end
        S_DONE: begin
          hash_out       <= chain;
          hash_valid_out <= 1'b1;
          byte_cnt       <= '0;
          msg_done       <= 1'b0;
          pad_pending    <= 1'b0;
          final_blk      <= 1'b0;
          word_idx       <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// tb/tb_sha256_msg_feeder.sv - self-checking bench for sha256_msg_feeder with a SHA-256 core model
module tb_sha256_msg_feeder;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         msg_valid_in, msg_ready_out, msg_last_in;
  logic [31:0]  msg_data_in;
  logic [2:0]   msg_bytes_in;
  logic         core_start_out, core_valid_in;
  logic [511:0] core_message_out;
  logic [255:0] core_digest_out, core_digest_in;
  logic [255:0] hash_out;
  logic         hash_valid_out, busy_out;

  always #5 CLK = ~CLK;

  sha256_msg_feeder #(.LEN_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .msg_valid_in(msg_valid_in), .msg_ready_out(msg_ready_out), .msg_data_in(msg_data_in),
    .msg_last_in(msg_last_in), .msg_bytes_in(msg_bytes_in),
    .core_start_out(core_start_out), .core_message_out(core_message_out),
    .core_digest_out(core_digest_out), .core_digest_in(core_digest_in),
    .core_valid_in(core_valid_in), .hash_out(hash_out), .hash_valid_out(hash_valid_out),
    .busy_out(busy_out)
  );

  localparam logic [255:0] H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] SHA_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [255:0] KAT_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] KAT_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] KAT_448   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  typedef struct {
    int           kind;   // 0: zlen zero bytes, 1: "abc", 2: 56-byte alphabet string
    int           zlen;
    logic [255:0] hash;   // known answer, 0 when only the model is used
    int           blocks;
    logic [31:0]  w0_last;
    logic [31:0]  w15_last;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  byte unsigned cur_msg[$];
  logic [511:0] exp_blocks[$];
  logic [255:0] exp_chains[$];
  logic         check_blocks = 1'b1;
  int           dmin = 2, dmax = 6;
  int           core_cnt = -1;
  int           starts = 0;
  int           ready_viol = 0;
  logic [511:0] cap_msg, last_blk;
  logic [255:0] cap_dig, cap_res;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
            e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
  endfunction

  // Reference: pad the byte string, slice into blocks, chain the compression.
  task automatic build_model(output logic [255:0] hfin, output int nblk);
    byte unsigned p[$];
    logic [511:0] blk;
    logic [63:0]  bits;
    p = cur_msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(cur_msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    exp_blocks.delete();
    exp_chains.delete();
    hfin = H0;
    nblk = p.size() / 64;
    for (int bi = 0; bi < nblk; bi++) begin
      for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*bi + j];
      exp_blocks.push_back(blk);
      exp_chains.push_back(hfin);
      hfin = sha_compress(hfin, blk);
    end
  endtask

  // Compression core model: captures at start, answers after a random delay.
  initial begin
    core_valid_in  = 1'b0;
    core_digest_in = '0;
    forever begin
      @(negedge CLK);
      core_valid_in = 1'b0;
      if (RST) core_cnt = -1;
      else begin
        if ((core_cnt >= 0 || core_start_out) && msg_ready_out) ready_viol++;
        if (core_start_out) begin
          starts++;
          cap_msg  = core_message_out;
          cap_dig  = core_digest_out;
          last_blk = cap_msg;
          cap_res  = sha_compress(cap_dig, cap_msg);
          core_cnt = $urandom_range(dmax, dmin);
          if (check_blocks && exp_blocks.size() != 0) begin
            check("block", cap_msg, exp_blocks.pop_front());
            check("chain_in", cap_dig, exp_chains.pop_front());
          end
        end else if (core_cnt > 0) begin
          core_cnt--;
          if (core_cnt == 0) begin
            check("msg_stable", core_message_out, cap_msg);
            check("dig_stable", core_digest_out, cap_dig);
            core_valid_in  = 1'b1;
            core_digest_in = cap_res;
            core_cnt       = -1;
          end
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input bit last, input logic [2:0] nb, input bit gaps);
    int t;
    t = 0;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        msg_valid_in = 1'b0;
        msg_data_in  = $urandom;
        @(negedge CLK);
      end
    end
    msg_valid_in = 1'b1;
    msg_data_in  = d;
    msg_last_in  = last;
    msg_bytes_in = nb;
    while (!msg_ready_out && t < 2000) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 2000) check("ready_timeout", t, 0);
    @(negedge CLK);
    msg_valid_in = 1'b0;
    msg_last_in  = 1'b0;
  endtask

  task automatic send_msg(input bit gaps);
    int n, nw;
    logic [31:0] d;
    logic [2:0]  nb;
    bit          last;
    n  = cur_msg.size();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      d    = $urandom;
      last = (w == nw - 1);
      nb   = last ? 3'(n - 4*w) : 3'($urandom_range(0, 7));
      for (int j = 0; j < 4; j++) if (4*w + j < n) d[31 - 8*j -: 8] = cur_msg[4*w + j];
      send_word(d, last, nb, gaps);
    end
  endtask

  task automatic run_msg(input string nm, input bit gaps, input logic [255:0] kat);
    logic [255:0] hexp;
    int nblk, t;
    build_model(hexp, nblk);
    starts     = 0;
    ready_viol = 0;
    send_msg(gaps);
    t = 0;
    while (!hash_valid_out && t < 20000) begin
      @(negedge CLK);
      t++;
    end
    check({nm, "_done"}, hash_valid_out, 1);
    check({nm, "_hash"}, hash_out, hexp);
    if (kat != 0) check({nm, "_kat"}, hash_out, kat);
    check({nm, "_starts"}, starts, nblk);
    check({nm, "_ready_low"}, ready_viol, 0);
    @(negedge CLK);
    check({nm, "_pulse"}, hash_valid_out, 0);
    check({nm, "_busy"}, busy_out, 0);
  endtask

  task automatic check_reset_outs(input string nm);
    check({nm, "_busy"}, busy_out, 0);
    check({nm, "_start"}, core_start_out, 0);
    check({nm, "_hvalid"}, hash_valid_out, 0);
    check({nm, "_msg"}, core_message_out, 0);
    check({nm, "_dig"}, core_digest_out, 0);
    check({nm, "_hash"}, hash_out, 0);
  endtask

  task automatic load_text(input string s);
    cur_msg.delete();
    for (int i = 0; i < s.len(); i++) cur_msg.push_back(s[i]);
  endtask

  initial begin
    vec_t vecs [5];
    int   bnd [12];
    int   t, len;

    msg_valid_in = 1'b0;
    msg_data_in  = '0;
    msg_last_in  = 1'b0;
    msg_bytes_in = '0;
    RST          = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset_outs("reset");
    RST = 1'b0;

    vecs[0] = '{0, 0,  KAT_EMPTY, 1, 32'h8000_0000, 32'h0000_0000};
    vecs[1] = '{1, 0,  KAT_ABC,   1, 32'h6162_6380, 32'h0000_0018};
    vecs[2] = '{2, 0,  KAT_448,   2, 32'h0000_0000, 32'h0000_01c0};
    vecs[3] = '{0, 55, 256'h0,    1, 32'h0000_0000, 32'h0000_01b8};
    vecs[4] = '{0, 64, 256'h0,    2, 32'h8000_0000, 32'h0000_0200};

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].kind == 1) load_text("abc");
      else if (vecs[i].kind == 2) load_text("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
      else begin
        cur_msg.delete();
        for (int j = 0; j < vecs[i].zlen; j++) cur_msg.push_back(8'h00);
      end
      run_msg($sformatf("vec%0d", i), 1'b0, vecs[i].hash);
      check($sformatf("vec%0d_blocks", i), starts, vecs[i].blocks);
      check($sformatf("vec%0d_w0_last", i), last_blk[511:480], vecs[i].w0_last);
      check($sformatf("vec%0d_w15_last", i), last_blk[31:0], vecs[i].w15_last);
    end

    // Random messages with source gaps; the first few with a slow core.
    bnd = '{0, 1, 3, 4, 52, 55, 56, 57, 63, 64, 119, 120};
    for (int i = 0; i < 12; i++) begin
      if (i < 4) begin dmin = 66; dmax = 200; end
      else       begin dmin = 1;  dmax = 10;  end
      len = ($urandom_range(0, 1) == 0) ? bnd[$urandom_range(0, 11)] : int'($urandom_range(0, 140));
      cur_msg.delete();
      for (int j = 0; j < len; j++) cur_msg.push_back(8'($urandom));
      run_msg($sformatf("rnd%0d_len%0d", i, len), 1'b1, 256'h0);
    end

    // Reset while the core is working on the first block of an unfinished message.
    check_blocks = 1'b0;
    dmin = 150;
    dmax = 150;
    for (int w = 0; w < 16; w++) send_word($urandom, 1'b0, 3'd4, 1'b0);
    t = 0;
    while (core_cnt < 0 && t < 200) begin
      @(negedge CLK);
      t++;
    end
    repeat (10) @(negedge CLK);
    check("rst_pre_busy", busy_out, 1);
    RST = 1'b1;
    @(negedge CLK);
    check_reset_outs("rst_mid");
    @(negedge CLK);
    RST = 1'b0;
    check_blocks = 1'b1;
    dmin = 2;
    dmax = 6;
    load_text("abc");
    run_msg("rst_abc", 1'b1, KAT_ABC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
